// File: rtl/mem_copy_engine.sv
// rtl/mem_copy_engine.sv - word-by-word memory copy / fill engine with registered outputs
//
// Purpose: on a start strobe, either copies len_i words from src_i to dst_i
// (READ -> CAPTURE -> WRITE per word, strictly ascending) or fills len_i words
// at dst_i with fill_value_i (one WRITE per word). Addresses wrap modulo
// 2^ADDR_SIZE. Every output comes straight from a register.
//
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   start_i, mode_i       command strobe (IDLE only), 0 = copy / 1 = fill
//   src_i, dst_i, len_i   source base, destination base, word count
//   fill_value_i          fill pattern
//   abort_i               cancel an active command
//   busy_o, done_o        command active, one-cycle completion pulse
//   count_o               words written for the current or last command
//   mem_addr_o            memory address
//   mem_value_o           memory write data
//   mem_write_o           memory write enable
//   mem_value_i           memory read data, valid one cycle after its address
module mem_copy_engine #(
  parameter int WORD_SIZE = 20,
  parameter int ADDR_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start_i,
  input  logic                 mode_i,
  input  logic [ADDR_SIZE-1:0] src_i,
  input  logic [ADDR_SIZE-1:0] dst_i,
  input  logic [ADDR_SIZE-1:0] len_i,
  input  logic [WORD_SIZE-1:0] fill_value_i,
  input  logic                 abort_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [ADDR_SIZE-1:0] count_o,
  output logic [ADDR_SIZE-1:0] mem_addr_o,
  output logic [WORD_SIZE-1:0] mem_value_o,
  output logic                 mem_write_o,
  input  logic [WORD_SIZE-1:0] mem_value_i
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    CAPTURE = 3'd2,
    WRITE   = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t               state, state_next;
  logic                 mode, mode_next;
  logic [ADDR_SIZE-1:0] src, src_next;
  logic [ADDR_SIZE-1:0] dst, dst_next;
  logic [ADDR_SIZE-1:0] len, len_next;
  logic [WORD_SIZE-1:0] fill, fill_next;
  logic [ADDR_SIZE-1:0] count, count_next;
  logic [ADDR_SIZE-1:0] count_inc;
  logic                 busy, busy_next;
  logic                 done, done_next;
  logic [ADDR_SIZE-1:0] addr, addr_next;
  logic [WORD_SIZE-1:0] value, value_next;
  logic                 write, write_next;

  // count doubles as the word index k of the word in flight
  assign count_inc = count + ADDR_SIZE'(1);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      mode  <= 1'b0;
      src   <= '0;
      dst   <= '0;
      len   <= '0;
      fill  <= '0;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      addr  <= '0;
      value <= '0;
      write <= 1'b0;
    end else begin
      state <= state_next;
      mode  <= mode_next;
      src   <= src_next;
      dst   <= dst_next;
      len   <= len_next;
      fill  <= fill_next;
      count <= count_next;
      busy  <= busy_next;
      done  <= done_next;
      addr  <= addr_next;
      value <= value_next;
      write <= write_next;
    end
  end

  // Next-state logic also computes the next value of every output register,
  // so outputs describe the state being entered, one cycle after the decision.
  always_comb begin
    state_next = state;
    mode_next  = mode;
    src_next   = src;
    dst_next   = dst;
    len_next   = len;
    fill_next  = fill;
    count_next = count;
    busy_next  = busy;
    done_next  = 1'b0;
    addr_next  = addr;
    value_next = value;
    write_next = 1'b0;

    case (state)
      IDLE: begin
        busy_next = 1'b0;
        if (start_i) begin
          mode_next  = mode_i;
          src_next   = src_i;
          dst_next   = dst_i;
          len_next   = len_i;
          fill_next  = fill_value_i;
          count_next = '0;
          if (len_i == '0) begin
            state_next = DONE;
            done_next  = 1'b1;
          end else if (mode_i) begin
            state_next = WRITE;
            busy_next  = 1'b1;
            addr_next  = dst_i;
            value_next = fill_value_i;
            write_next = 1'b1;
          end else begin
            state_next = READ;
            busy_next  = 1'b1;
            addr_next  = src_i;
          end
        end
      end

      READ: begin
        if (abort_i) begin
          state_next = IDLE;
          busy_next  = 1'b0;
        end else begin
          state_next = CAPTURE;
        end
      end

      CAPTURE: begin
        if (abort_i) begin
          state_next = IDLE;
          busy_next  = 1'b0;
        end else begin
          // read data is valid in this cycle; it goes straight into the
          // write-data register for the following WRITE cycle
          state_next = WRITE;
          addr_next  = dst + count;
          value_next = mem_value_i;
          write_next = 1'b1;
        end
      end

      WRITE: begin
        // the write presented this cycle always lands, even under abort
        count_next = count_inc;
        if (abort_i) begin
          state_next = IDLE;
          busy_next  = 1'b0;
        end else if (count_inc == len) begin
          state_next = DONE;
          busy_next  = 1'b0;
          done_next  = 1'b1;
        end else if (mode) begin
          addr_next  = dst + count_inc;
          value_next = fill;
          write_next = 1'b1;
        end else begin
          state_next = READ;
          addr_next  = src + count_inc;
        end
      end

      DONE: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end

      default: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  assign busy_o      = busy;
  assign done_o      = done;
  assign count_o     = count;
  assign mem_addr_o  = addr;
  assign mem_value_o = value;
  assign mem_write_o = write;

endmodule

// File: tb/tb_mem_copy_engine.sv
// tb/tb_mem_copy_engine.sv - table-driven self-checking bench for mem_copy_engine
module tb_mem_copy_engine;

  localparam int W = 20;
  localparam int A = 16;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start_i;
  logic         mode_i;
  logic [A-1:0] src_i, dst_i, len_i;
  logic [W-1:0] fill_value_i;
  logic         abort_i;
  logic         busy_o, done_o;
  logic [A-1:0] count_o, mem_addr_o;
  logic [W-1:0] mem_value_o;
  logic         mem_write_o;
  logic [W-1:0] mem_value_i;

  always #5 clk = ~clk;

  mem_copy_engine #(.WORD_SIZE(W), .ADDR_SIZE(A)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start_i      (start_i),
    .mode_i       (mode_i),
    .src_i        (src_i),
    .dst_i        (dst_i),
    .len_i        (len_i),
    .fill_value_i (fill_value_i),
    .abort_i      (abort_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .count_o      (count_o),
    .mem_addr_o   (mem_addr_o),
    .mem_value_o  (mem_value_o),
    .mem_write_o  (mem_write_o),
    .mem_value_i  (mem_value_i)
  );

  // synchronous RAM: read data valid the cycle after the address
  logic [W-1:0] ram   [0:65535];
  logic [W-1:0] model [0:65535];
  logic         pre_we = 1'b0;
  logic [A-1:0] pre_addr = '0;
  logic [W-1:0] pre_data = '0;

  always @(posedge clk) begin
    mem_value_i <= ram[mem_addr_o];
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (mem_write_o) ram[mem_addr_o] <= mem_value_o;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [A-1:0] a, input logic [W-1:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    model[a] = d;
    @(posedge clk);
    #1 pre_we = 1'b0;
  endtask

  typedef struct {
    string        name;
    logic         mode;
    logic [A-1:0] src;
    logic [A-1:0] dst;
    logic [A-1:0] len;
    logic [W-1:0] fill;
    int           exp_cycles;  // edges from start edge (inclusive) to done_o seen
  } vec_t;

  task automatic issue(input logic mode, input logic [A-1:0] src, input logic [A-1:0] dst,
                       input logic [A-1:0] len, input logic [W-1:0] fill);
    @(negedge clk);
    start_i = 1'b1; mode_i = mode; src_i = src; dst_i = dst; len_i = len; fill_value_i = fill;
    @(posedge clk);
    #1 start_i = 1'b0;
  endtask

  task automatic run_cmd(input vec_t v);
    logic [A-1:0] exp_a [$];
    logic [W-1:0] exp_d [$];
    logic [A-1:0] a;
    logic [W-1:0] d;
    int n, got;
    bit seen_done;
    for (int k = 0; k < int'(v.len); k++) begin
      a = v.dst + A'(k);
      if (v.mode) d = v.fill;
      else begin
        logic [A-1:0] s;
        s = v.src + A'(k);
        d = model[s];
      end
      model[a] = d;
      exp_a.push_back(a);
      exp_d.push_back(d);
    end
    issue(v.mode, v.src, v.dst, v.len, v.fill);
    n = 1; got = 0; seen_done = 0;
    while (n <= 200 && !seen_done) begin
      @(negedge clk);
      if (n == 1 && v.len != 0) check({v.name, "_busy"}, 32'(busy_o), 32'd1);
      if (mem_write_o) begin
        if (got < exp_a.size()) begin
          check($sformatf("%s_addr%0d", v.name, got), 32'(mem_addr_o), 32'(exp_a[got]));
          check($sformatf("%s_data%0d", v.name, got), 32'(mem_value_o), 32'(exp_d[got]));
        end
        got++;
      end
      if (done_o) begin
        seen_done = 1;
        check({v.name, "_cycles"}, 32'(n), 32'(v.exp_cycles));
        check({v.name, "_busy_at_done"}, 32'(busy_o), 32'd0);
        check({v.name, "_count"}, 32'(count_o), 32'(v.len));
      end else begin
        @(posedge clk);
        n++;
      end
    end
    check({v.name, "_done_seen"}, 32'(seen_done), 32'd1);
    check({v.name, "_num_writes"}, 32'(got), 32'(v.len));
    @(negedge clk);
    check({v.name, "_done_one_cycle"}, 32'(done_o), 32'd0);
  endtask

  vec_t vecs [4];

  initial begin
    int writes, dones, n;
    vec_t v;

    vecs[0] = '{"copy",    1'b0, 16'h0010, 16'h0020, 16'd3, 20'h0,     10};
    vecs[1] = '{"overlap", 1'b0, 16'h0000, 16'h0001, 16'd3, 20'h0,     10};
    vecs[2] = '{"fill",    1'b1, 16'h0000, 16'hFFFE, 16'd4, 20'hABCDE, 5};
    vecs[3] = '{"zerolen", 1'b0, 16'h0000, 16'h0050, 16'd0, 20'h12345, 1};

    for (int i = 0; i < 65536; i++) model[i] = '0;
    reset_n = 1'b0; start_i = 1'b1; abort_i = 1'b1; mode_i = 1'b1;
    src_i = '0; dst_i = '0; len_i = 16'd5; fill_value_i = '0;

    // reset overrides start/abort; clear RAM while held
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      pre_we = 1'b1; pre_addr = A'(i); pre_data = '0;
      if (i == 7) begin
        for (int j = 0; j < 8; j++) begin end
      end
    end
    @(negedge clk);
    pre_we = 1'b0;
    check("rst_busy",  32'(busy_o),      32'd0);
    check("rst_done",  32'(done_o),      32'd0);
    check("rst_count", 32'(count_o),     32'd0);
    check("rst_addr",  32'(mem_addr_o),  32'd0);
    check("rst_value", 32'(mem_value_o), 32'd0);
    check("rst_write", 32'(mem_write_o), 32'd0);
    start_i = 1'b0; abort_i = 1'b0; reset_n = 1'b1;

    preload(16'h0010, 20'd5);
    preload(16'h0011, 20'd6);
    preload(16'h0012, 20'd7);
    preload(16'h0000, 20'd1);
    preload(16'h0001, 20'd2);
    preload(16'h0002, 20'd3);
    preload(16'h0003, 20'd4);

    for (int i = 0; i < 4; i++) begin
      run_cmd(vecs[i]);
      if (i == 1) begin
        check("overlap_ram0", 32'(ram[0]), 32'd1);
        check("overlap_ram1", 32'(ram[1]), 32'd1);
        check("overlap_ram2", 32'(ram[2]), 32'd1);
        check("overlap_ram3", 32'(ram[3]), 32'd1);
      end
    end

    // abort on the 3rd WRITE of a fill; stray start while busy is ignored
    issue(1'b1, 16'h0000, 16'h0100, 16'd8, 20'h11111);
    writes = 0; n = 0;
    while (writes < 3 && n < 50) begin
      @(negedge clk);
      if (mem_write_o) begin
        writes++;
        if (writes == 2) begin
          start_i = 1'b1; mode_i = 1'b0; len_i = 16'd0;
        end
        if (writes == 3) begin
          start_i = 1'b0; abort_i = 1'b1;
        end
      end
      n++;
    end
    check("abort_reached_3rd_write", 32'(writes), 32'd3);
    @(posedge clk);
    #1 abort_i = 1'b0;
    @(negedge clk);
    check("abort_busy",  32'(busy_o),      32'd0);
    check("abort_write", 32'(mem_write_o), 32'd0);
    check("abort_done",  32'(done_o),      32'd0);
    check("abort_count", 32'(count_o),     32'd3);
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_write_o) writes++;
      if (done_o) dones++;
    end
    check("abort_total_writes", 32'(writes), 32'd3);
    check("abort_no_done", 32'(dones), 32'd0);
    for (int k = 0; k < 3; k++) model[16'h0100 + k] = 20'h11111;

    // reset during CAPTURE of word 1 of a copy
    issue(1'b0, 16'h0010, 16'h0040, 16'd3, 20'h0);
    writes = 0;
    for (n = 1; n <= 5; n++) begin
      @(negedge clk);
      if (mem_write_o) writes++;
      if (n < 5) @(posedge clk);
    end
    check("cap1_addr",  32'(mem_addr_o),  32'h0011);
    check("cap1_write", 32'(mem_write_o), 32'd0);
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst_busy",  32'(busy_o),      32'd0);
    check("midrst_done",  32'(done_o),      32'd0);
    check("midrst_count", 32'(count_o),     32'd0);
    check("midrst_addr",  32'(mem_addr_o),  32'd0);
    check("midrst_value", 32'(mem_value_o), 32'd0);
    check("midrst_write", 32'(mem_write_o), 32'd0);
    reset_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (mem_write_o) writes++;
      if (done_o) dones++;
    end
    check("midrst_total_writes", 32'(writes), 32'd1);
    check("midrst_no_done", 32'(dones), 32'd0);
    model[16'h0040] = model[16'h0010];

    v = '{"post_reset", 1'b1, 16'h0000, 16'h0060, 16'd2, 20'h0F0F0, 3};
    run_cmd(v);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
